// File: rtl/exec_seq_pkg.sv
// Shared types for the per-PE execution loop sequencer.
// The state encoding is fixed so that debug dumps stay comparable across revisions.
package exec_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/vec_step_counter.sv
// Wrapping lane counter: counts 0..limit while step is high, wrap flags the last lane.
// count_next is exported so the parent can register signals that depend on the next lane.
module vec_step_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    assign wrap = (count == limit);

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (step) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (en) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/exec_loop_sequencer.sv
// Per-PE execution controller: arms the loop, sweeps addr_cmem over the configured
// window, gates the iteration-counter clock and drains the datapath after exec_end.
module exec_loop_sequencer
    import exec_seq_pkg::*;
#(
    parameter int CONFIG_MEM_BITS = 3,
    parameter int VEC_WIDTH       = 4,
    parameter int DRAIN_CYCLES    = 2,
    parameter int CYCLE_BITS      = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         chip_en,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CONFIG_MEM_BITS-1:0]   loop_start,
    input  logic [CONFIG_MEM_BITS-1:0]   loop_end,
    input  logic [$clog2(VEC_WIDTH)-1:0] vec_size,
    input  logic                         exec_end_in,
    output logic                         start_exec,
    output logic                         start_exec_shifted,
    output logic                         clken_vec,
    output logic [$clog2(VEC_WIDTH)-1:0] vec_counter,
    output logic [CONFIG_MEM_BITS:0]     addr_cmem,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic [CYCLE_BITS-1:0]        run_cycles
);

    localparam int VEC_WIDTH_BITS = $clog2(VEC_WIDTH);
    localparam int AW             = CONFIG_MEM_BITS + 1;
    localparam int DRAIN_BITS     = $clog2(DRAIN_CYCLES + 1);

    exec_state_t               state;
    exec_state_t               state_next;
    logic                      start_q;
    logic                      req;
    logic                      bad_bounds;
    logic                      wrap;
    logic                      step_now;
    logic                      end_hit;
    logic                      vc_clr;
    logic                      vc_step;
    logic [VEC_WIDTH_BITS-1:0] vc_next;
    logic [AW-1:0]             addr_next;
    logic [AW-1:0]             ls_ext;
    logic [AW-1:0]             le_ext;
    logic [DRAIN_BITS-1:0]     drain_cnt;
    logic                      clken_next;

    assign req        = start & ~start_q & chip_en;
    assign bad_bounds = (loop_start > loop_end);
    assign ls_ext     = {1'b0, loop_start};
    assign le_ext     = {1'b0, loop_end};
    assign step_now   = (state == RUN) && wrap;
    assign end_hit    = step_now && exec_end_in && (addr_cmem == le_ext);

    assign start_exec = (state == ARM) || (state == RUN);
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);

    // abort outranks every state transition; chip_en gating happens at the registers
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (req) state_next = bad_bounds ? DONE : ARM;
                ARM:     state_next = RUN;
                RUN:     if (end_hit) state_next = DRAIN;
                DRAIN:   if (drain_cnt == '0) state_next = DONE;
                DONE:    if (!start) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign vc_clr  = (state == IDLE) || (state_next == IDLE);
    assign vc_step = (state == RUN) && !end_hit;

    vec_step_counter #(
        .WIDTH(VEC_WIDTH_BITS)
    ) u_vec_step_counter (
        .clk        (clk),
        .rstn       (rstn),
        .en         (chip_en),
        .clr        (vc_clr),
        .step       (vc_step),
        .limit      (vec_size),
        .count      (vec_counter),
        .count_next (vc_next),
        .wrap       (wrap)
    );

    // Address stepper: out-of-window addresses snap back to loop_start
    always_comb begin
        addr_next = addr_cmem;
        if (state_next == IDLE) begin
            addr_next = '0;
        end else if ((state == IDLE) && req && !bad_bounds) begin
            addr_next = ls_ext;
        end else if (step_now && !end_hit) begin
            if ((addr_cmem >= le_ext) || (addr_cmem < ls_ext)) begin
                addr_next = ls_ext;
            end else begin
                addr_next = addr_cmem + 1'b1;
            end
        end
    end

    // clken_vec is registered, so it is derived from the next state and next lane
    always_comb begin
        case (state_next)
            IDLE:    clken_next = 1'b1;
            RUN:     clken_next = (vc_next == vec_size);
            DONE:    clken_next = 1'b1;
            default: clken_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= IDLE;
            addr_cmem          <= '0;
            clken_vec          <= 1'b1;
            start_exec_shifted <= 1'b0;
            drain_cnt          <= '0;
            cfg_err            <= 1'b0;
            run_cycles         <= '0;
        end else if (chip_en) begin
            state              <= state_next;
            addr_cmem          <= addr_next;
            clken_vec          <= clken_next;
            start_exec_shifted <= (state_next == RUN);

            if (abort) begin
                drain_cnt <= '0;
            end else if ((state == RUN) && end_hit) begin
                drain_cnt <= DRAIN_BITS'(DRAIN_CYCLES - 1);
            end else if ((state == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            if (abort) begin
                cfg_err    <= 1'b0;
                run_cycles <= '0;
            end else if ((state == IDLE) && req) begin
                cfg_err <= bad_bounds;
                if (!bad_bounds) begin
                    run_cycles <= '0;
                end
            end else if ((state == RUN) && (run_cycles != {CYCLE_BITS{1'b1}})) begin
                run_cycles <= run_cycles + 1'b1;
            end
        end
    end

endmodule
